// File: rtl/mycpu_pkg.sv
// mycpu_pkg
// Shared CPU types used by the write-register scoreboard and its per-register
// entries: register address type, result-source encoding, the decoded write
// descriptor carried by each issue lane, and the scoreboard's default sizes.
package mycpu_pkg;

    typedef logic [4:0] creg_addr_t;

    // Where an in-flight result comes from; only ALU results can be bypassed.
    typedef enum logic [1:0] {
        SRC_NOP = 2'd0,
        SRC_ALU = 2'd1,
        SRC_MEM = 2'd2
    } src_t;

    typedef struct packed {
        logic       valid;
        src_t       src;
        creg_addr_t dst;
    } write_reg_t;

    localparam int SB_ISSUE_W = 2;
    localparam int SB_WB_W    = 2;
    localparam int SB_CNT_W   = 2;

    // Width of the per-cycle lane counts; comfortably above any lane count.
    localparam int LANE_CNT_W = 8;

endpackage

// File: rtl/sb_entry.sv
// sb_entry
// Tracks one architectural register (IDX, 1..31) for the write scoreboard:
// the number of in-flight writers and the source of the youngest accepted one.
// Ports:
//   clk, resetn      - clock, synchronous active-low reset
//   flush            - discard all in-flight writes on the next edge
//   accept           - the current issue bundle is accepted this cycle
//   iss_valid/iss_wr - issue lanes and their write descriptors
//   wb_valid/wb_dst  - writeback lanes and their destinations
//   busy             - at least one writer in flight
//   alu_youngest     - youngest in-flight writer is an ALU op (bypassable)
//   would_overflow   - the current bundle would push the counter past max
//   underflow        - writeback count exceeds what is in flight this cycle
module sb_entry
    import mycpu_pkg::*;
#(
    parameter int IDX     = 1,
    parameter int ISSUE_W = SB_ISSUE_W,
    parameter int WB_W    = SB_WB_W,
    parameter int CNT_W   = SB_CNT_W
) (
    input  logic                            clk,
    input  logic                            resetn,
    input  logic                            flush,
    input  logic                            accept,
    input  logic [ISSUE_W-1:0]              iss_valid,
    input  write_reg_t [ISSUE_W-1:0]        iss_wr,
    input  logic [WB_W-1:0]                 wb_valid,
    input  creg_addr_t [WB_W-1:0]           wb_dst,
    output logic                            busy,
    output logic                            alu_youngest,
    output logic                            would_overflow,
    output logic                            underflow
);

    localparam logic [15:0] CNT_MAX = 16'((1 << CNT_W) - 1);

    logic [CNT_W-1:0]      cnt_q;
    src_t                  ysrc_q;
    logic [LANE_CNT_W-1:0] inc_n;
    logic [LANE_CNT_W-1:0] dec_n;
    src_t                  inc_src;
    logic [15:0]           total;
    logic [CNT_W-1:0]      cnt_d;

    // Count this register's writers in the bundle and writebacks; the last
    // matching lane in program order decides the youngest source.
    always_comb begin
        inc_n   = '0;
        inc_src = SRC_NOP;
        dec_n   = '0;
        for (int i = 0; i < ISSUE_W; i++) begin
            if (iss_valid[i] && iss_wr[i].valid && iss_wr[i].dst == creg_addr_t'(IDX)) begin
                inc_n   = inc_n + LANE_CNT_W'(1);
                inc_src = iss_wr[i].src;
            end
        end
        for (int j = 0; j < WB_W; j++) begin
            if (wb_valid[j] && wb_dst[j] == creg_addr_t'(IDX)) begin
                dec_n = dec_n + LANE_CNT_W'(1);
            end
        end
    end

    // Overflow is judged before writebacks net out, so a full counter
    // blocks a new writer even if a retirement lands in the same cycle.
    // An impossible decrement is dropped entirely, keeping any increment.
    always_comb begin
        would_overflow = (16'(cnt_q) + 16'(inc_n)) > CNT_MAX;
        total          = 16'(cnt_q) + (accept ? 16'(inc_n) : 16'd0);
        underflow      = 16'(dec_n) > total;
        cnt_d          = underflow ? CNT_W'(total) : CNT_W'(total - 16'(dec_n));
    end

    // Reset beats flush, flush beats issue and writeback.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt_q  <= '0;
            ysrc_q <= SRC_NOP;
        end else if (flush) begin
            cnt_q  <= '0;
            ysrc_q <= SRC_NOP;
        end else begin
            cnt_q <= cnt_d;
            if (accept && inc_n != '0) begin
                ysrc_q <= inc_src;
            end
        end
    end

    assign busy         = (cnt_q != '0);
    assign alu_youngest = (ysrc_q == SRC_ALU);

endmodule

// File: rtl/write_reg_scoreboard.sv
// write_reg_scoreboard
// Register-write scoreboard for a multi-issue pipeline. Tracks in-flight
// writers of r1..r31 and stalls a bundle that reads a non-forwardable pending
// result, reads a non-forwardable result of an older lane in the same bundle,
// or would overflow a per-register counter.
// Ports:
//   clk, resetn - clock, synchronous active-low reset
//   iss_valid   - per-lane instruction valid
//   iss_wr      - per-lane write descriptor (valid, src, dst)
//   iss_rs/rt   - per-lane source registers
//   iss_ready   - bundle accepted this cycle (combinational)
//   wb_valid    - per-lane writeback valid
//   wb_dst      - per-lane retired destination
//   flush       - discard all in-flight writes
//   busy_mask   - bit r set while r has writers in flight
//   err         - sticky underflow/overflow flag
module write_reg_scoreboard
    import mycpu_pkg::*;
#(
    parameter int ISSUE_W = SB_ISSUE_W,
    parameter int WB_W    = SB_WB_W,
    parameter int CNT_W   = SB_CNT_W,
    parameter int ALU_FWD = 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [ISSUE_W-1:0]       iss_valid,
    input  write_reg_t [ISSUE_W-1:0] iss_wr,
    input  creg_addr_t [ISSUE_W-1:0] iss_rs,
    input  creg_addr_t [ISSUE_W-1:0] iss_rt,
    output logic                     iss_ready,
    input  logic [WB_W-1:0]          wb_valid,
    input  creg_addr_t [WB_W-1:0]    wb_dst,
    input  logic                     flush,
    output logic [31:0]              busy_mask,
    output logic                     err
);

    logic [31:0] busy_vec;
    logic [31:0] alu_vec;
    logic [31:0] ovf_vec;
    logic [31:0] udf_vec;
    logic        hazard;
    logic        bundle_ovf;
    creg_addr_t  src_reg;
    logic        fwd_found;
    src_t        fwd_src;

    // r0 is hardwired and never tracked.
    assign busy_vec[0] = 1'b0;
    assign alu_vec[0]  = 1'b0;
    assign ovf_vec[0]  = 1'b0;
    assign udf_vec[0]  = 1'b0;

    for (genvar r = 1; r < 32; r++) begin : g_entry
        sb_entry #(
            .IDX     (r),
            .ISSUE_W (ISSUE_W),
            .WB_W    (WB_W),
            .CNT_W   (CNT_W)
        ) u_entry (
            .clk            (clk),
            .resetn         (resetn),
            .flush          (flush),
            .accept         (iss_ready),
            .iss_valid      (iss_valid),
            .iss_wr         (iss_wr),
            .wb_valid       (wb_valid),
            .wb_dst         (wb_dst),
            .busy           (busy_vec[r]),
            .alu_youngest   (alu_vec[r]),
            .would_overflow (ovf_vec[r]),
            .underflow      (udf_vec[r])
        );
    end

    // Each source of each valid lane is checked against registered state and
    // against the youngest older writer of the same register in the bundle.
    always_comb begin
        hazard    = 1'b0;
        src_reg   = '0;
        fwd_found = 1'b0;
        fwd_src   = SRC_NOP;
        for (int i = 0; i < ISSUE_W; i++) begin
            for (int p = 0; p < 2; p++) begin
                src_reg   = (p == 0) ? iss_rs[i] : iss_rt[i];
                fwd_found = 1'b0;
                fwd_src   = SRC_NOP;
                for (int k = 0; k < i; k++) begin
                    if (iss_valid[k] && iss_wr[k].valid && iss_wr[k].dst == src_reg) begin
                        fwd_found = 1'b1;
                        fwd_src   = iss_wr[k].src;
                    end
                end
                if (iss_valid[i] && src_reg != '0) begin
                    if (busy_vec[src_reg] && (!alu_vec[src_reg] || ALU_FWD == 0)) begin
                        hazard = 1'b1;
                    end
                    if (fwd_found && (fwd_src != SRC_ALU || ALU_FWD == 0)) begin
                        hazard = 1'b1;
                    end
                end
            end
        end
    end

    assign bundle_ovf = |ovf_vec;
    assign iss_ready  = !hazard && !bundle_ovf && !flush;
    assign busy_mask  = busy_vec;

    // The overflow term is a safety net: iss_ready already refuses such
    // bundles, so it only fires if the gating above is ever broken.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            err <= 1'b0;
        end else if (!flush && ((|udf_vec) || (iss_ready && bundle_ovf))) begin
            err <= 1'b1;
        end
    end

endmodule

// File: doc/write_reg_scoreboard.md
WRITE_REG_SCOREBOARD -- requirements
Module: write_reg_scoreboard

Interface
REQ-001 SHALL have parameter ISSUE_W, default 2, number of issue lanes per bundle.
REQ-002 SHALL have parameter WB_W, default 2, number of writeback/complete lanes.
REQ-003 SHALL have parameter CNT_W, default 2, width of each per-register in-flight counter.
REQ-004 SHALL have parameter ALU_FWD, default 1; 1 means SRC_ALU results are forwardable.
REQ-005 SHALL have port clk, input, 1, sole clock; one clock, reset synchronous active-low.
REQ-006 SHALL have port resetn, input, 1, synchronous active-low reset.
REQ-007 SHALL have port iss_valid, input, ISSUE_W, lane i carries an instruction.
REQ-008 SHALL have port iss_wr, input, ISSUE_W x write_reg_t, decoded write descriptor (valid, src, dst) per lane.
REQ-009 SHALL have port iss_rs, input, ISSUE_W x creg_addr_t, first source register per lane.
REQ-010 SHALL have port iss_rt, input, ISSUE_W x creg_addr_t, second source register per lane.
REQ-011 SHALL have port iss_ready, output, 1, bundle accepted this cycle.
REQ-012 SHALL have port wb_valid, input, WB_W, lane j retires a write.
REQ-013 SHALL have port wb_dst, input, WB_W x creg_addr_t, retired destination.
REQ-014 SHALL have port flush, input, 1, discard all in-flight writes.
REQ-015 SHALL have port busy_mask, output, 32, bit r set when cnt[r] nonzero.
REQ-016 SHALL have port err, output, 1, sticky underflow/overflow flag.

Function
REQ-017 SHALL keep per register r in 1..31: cnt[r] (CNT_W bits) and ysrc[r], the src of the youngest accepted writer; register 0 SHALL never be tracked.
REQ-018 SHALL treat a source reg s as hazard when cnt[s]!=0 and (ysrc[s]!=SRC_ALU or ALU_FWD==0).
REQ-019 SHALL treat lane i reading a dst written by valid lane k<i of the same bundle as hazard; its src is the lane-k src under the rule of REQ-018.
REQ-020 SHALL treat a bundle as overflow when cnt[r] + its increments to r exceeds 2^CNT_W-1 for any r.
REQ-021 SHALL drive iss_ready combinationally: 1 iff no hazard, no overflow, and flush==0; all-or-nothing per bundle.
REQ-022 SHALL increment cnt[dst] once per valid lane with iss_wr.valid && dst!=0 on the edge where iss_ready==1; ysrc[dst] SHALL take the src of the highest-index such lane.
REQ-023 SHALL decrement cnt[wb_dst] once per wb_valid lane with wb_dst!=0; same-cycle increment and decrement of one reg SHALL net (cnt+inc-dec).
REQ-024 SHALL ignore a decrement that would take cnt below 0 (cnt held) and set err.
REQ-025 SHALL set err if an accepted bundle would overflow; cannot occur when REQ-021 holds and exists as an internal check.
REQ-026 SHALL, on flush==1, zero all cnt and ysrc on the next edge; flush SHALL override same-cycle issue and writeback.
REQ-027 SHALL reflect updated state in busy_mask and hazards one cycle after the updating edge; no same-cycle bypass of wb into hazard.

Reset
REQ-028 SHALL, when resetn==0 at a clk edge, clear all cnt, ysrc=SRC_NOP, err=0.
REQ-029 SHALL therefore output busy_mask=0 after reset; iss_ready then follows REQ-021 combinationally.
REQ-030 SHALL make reset asserted mid-operation override flush, issue and writeback in that cycle.

Structure
REQ-031 SHALL take write_reg_t, creg_addr_t and the SRC_ALU/SRC_MEM/SRC_NOP encodings from the shared mycpu package; no local redefinition.
REQ-032 SHALL put ISSUE_W/WB_W/CNT_W defaults in the shared package as named constants.
REQ-033 SHALL instantiate 31 copies of sub-module sb_entry, each one register's counter, ysrc and inc/dec/flush logic.

Verification
REQ-034 Issue LW r5 (SRC_MEM), next cycle ADDU r6 reading r5 -> iss_ready=0 until wb_dst=5 retires, then 1 the following cycle.
REQ-035 Issue ADDU r7 (SRC_ALU), ALU_FWD=1, next cycle reader of r7 -> iss_ready=1, busy_mask[7]=1.
REQ-036 Bundle lane0 LW r3, lane1 reads r3 -> iss_ready=0; lane0 ADDU r3, lane1 reads r3 -> iss_ready=1.
REQ-037 CNT_W=2: three accepted writes to r9, fourth -> iss_ready=0, cnt[9]=3, err=0.
REQ-038 wb_valid with dst=12 while cnt[12]=0 -> cnt stays 0, err=1 and sticky until reset.
REQ-039 Pending r4,r5 plus same-cycle flush, issue and wb -> busy_mask=0 next cycle; resetn=0 mid-run -> busy_mask=0, err=0 next cycle.
